fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core; sits directly upstream of decode and feeds the opcode classifier and register-file read.
- Owns the PC and generates the instruction-memory address, which memory returns combinationally.
- Latches instruction and PC+4 for decode, and applies hazard-unit stall/flush and decode-stage branch/jump redirects.
- Runs a small BOOT/RUN/HALTED state machine so the pipeline freezes once a SYSCALL/BREAK is classified in decode.

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, IF/ID register, redirect buffering and BOOT/RUN/HALTED control
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic        halt_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        halted
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] next_seq, branch_tgt;
    logic [31:0] pc_n, instr_n, pc_plus4_n, redirect_target, redirect_target_n;
    logic        valid_n, redirect_pending, redirect_pending_n;

    assign imem_addr  = pc_f;
    assign next_seq   = pc_f + 32'd4;
    assign branch_tgt = {pc_branch_d[31:2], 2'b00};
    assign halted     = state == HALTED;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= BOOT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = RUN;
            RUN:     state_n = (halt_d && !flush_d) ? HALTED : RUN;
            default: state_n = HALTED;
        endcase
    end

    // A stalled redirect is parked and applied on the first unstalled edge
    always_comb begin
        pc_n               = pc_f;
        instr_n            = instr_d;
        pc_plus4_n         = pc_plus4_d;
        valid_n            = valid_d;
        redirect_pending_n = redirect_pending;
        redirect_target_n  = redirect_target;
        if (state == HALTED) begin
            instr_n    = 32'd0;
            pc_plus4_n = 32'd0;
            valid_n    = 1'b0;
        end else if (state == RUN) begin
            if (flush_d || halt_d) begin
                instr_n    = 32'd0;
                pc_plus4_n = 32'd0;
                valid_n    = 1'b0;
            end else if (!stall_f) begin
                instr_n    = imem_data;
                pc_plus4_n = next_seq;
                valid_n    = 1'b1;
            end
            if (halt_d && !flush_d) begin
                pc_n = pc_f;
            end else if (stall_f) begin
                redirect_pending_n = redirect_pending | pc_src_d;
                redirect_target_n  = pc_src_d ? branch_tgt : redirect_target;
            end else begin
                pc_n               = pc_src_d ? branch_tgt : redirect_pending ? redirect_target : next_seq;
                redirect_pending_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc_f             <= RESET_PC;
            instr_d          <= 32'd0;
            pc_plus4_d       <= 32'd0;
            valid_d          <= 1'b0;
            redirect_pending <= 1'b0;
            redirect_target  <= 32'd0;
        end else begin
            pc_f             <= pc_n;
            instr_d          <= instr_n;
            pc_plus4_d       <= pc_plus4_n;
            valid_d          <= valid_n;
            redirect_pending <= redirect_pending_n;
            redirect_target  <= redirect_target_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage against directed expectations
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        stall_f = 1'b0, flush_d = 1'b0, pc_src_d = 1'b0, halt_d = 1'b0;
    logic [31:0] pc_branch_d = 32'd0;
    logic [31:0] imem_addr, imem_data, pc_f, instr_d, pc_plus4_d;
    logic        valid_d, halted;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_b(rst_b), .stall_f(stall_f), .flush_d(flush_d),
        .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d), .halt_d(halt_d),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc_f(pc_f),
        .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == RPC) ? 32'h2408_0005 : a ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = mem(imem_addr);

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] p4, input logic v, input logic h);
        exp_t e;
        e.pc = pc; e.instr = instr; e.p4 = p4; e.v = v; e.h = h;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic expect_now(input string tag, input exp_t e);
        check({tag, ".pc"}, pc_f, e.pc);
        check({tag, ".addr"}, imem_addr, e.pc);
        check({tag, ".instr"}, instr_d, e.instr);
        check({tag, ".p4"}, pc_plus4_d, e.p4);
        check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, e.v});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, e.h});
    endtask

    task automatic step(input string tag, input logic st, input logic fl, input logic ps,
                        input logic hd, input logic [31:0] br, input exp_t e);
        exp_t got;
        stall_f = st; flush_d = fl; pc_src_d = ps; halt_d = hd; pc_branch_d = br;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall_f = 0; flush_d = 0; pc_src_d = 0; halt_d = 0; pc_branch_d = 0;
        got = sb.pop_front();
        expect_now(tag, got);
    endtask

    task automatic idle(input string tag, input exp_t e);
        step(tag, 0, 0, 0, 0, 32'd0, e);
    endtask

    task automatic do_reset(input string tag);
        rst_b = 1'b0;
        #1;
        expect_now(tag, mk(RPC, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("rst");
        idle("boot", mk(RPC, 0, 0, 0, 0));
        idle("run0", mk(RPC + 4, 32'h2408_0005, RPC + 4, 1, 0));
        idle("run1", mk(RPC + 8, mem(RPC + 4), RPC + 8, 1, 0));
        step("stall0", 1, 0, 0, 0, 0, mk(RPC + 8, mem(RPC + 4), RPC + 8, 1, 0));
        step("stall1", 1, 0, 0, 0, 0, mk(RPC + 8, mem(RPC + 4), RPC + 8, 1, 0));
        idle("run2", mk(RPC + 12, mem(RPC + 8), RPC + 12, 1, 0));
        idle("run3", mk(RPC + 16, mem(RPC + 12), RPC + 16, 1, 0));
        step("br", 0, 1, 1, 0, 32'h0040_0103, mk(32'h0040_0100, 0, 0, 0, 0));
        idle("br_tgt", mk(32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0));
        step("pend0", 1, 0, 1, 0, 32'h0040_0300, mk(32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0));
        step("pend1", 1, 0, 1, 0, 32'h0040_0203, mk(32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0));
        step("pend2", 1, 0, 0, 0, 0, mk(32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0));
        idle("pend_go", mk(32'h0040_0200, mem(32'h0040_0104), 32'h0040_0108, 1, 0));
        idle("pend_clr", mk(32'h0040_0204, mem(32'h0040_0200), 32'h0040_0204, 1, 0));
        step("stfl", 1, 1, 0, 0, 0, mk(32'h0040_0204, 0, 0, 0, 0));
        idle("stfl_nx", mk(32'h0040_0208, mem(32'h0040_0204), 32'h0040_0208, 1, 0));
        step("flhalt", 0, 1, 0, 1, 0, mk(32'h0040_020C, 0, 0, 0, 0));
        step("to14", 0, 1, 1, 0, RPC + 20, mk(RPC + 20, 0, 0, 0, 0));
        idle("run14", mk(RPC + 24, mem(RPC + 20), RPC + 24, 1, 0));
        step("back14", 0, 1, 1, 0, RPC + 20, mk(RPC + 20, 0, 0, 0, 0));
        step("halt", 0, 0, 0, 1, 0, mk(RPC + 20, 0, 0, 0, 1));
        step("h_st", 1, 0, 0, 0, 0, mk(RPC + 20, 0, 0, 0, 1));
        step("h_fl", 0, 1, 1, 0, 32'h0040_0800, mk(RPC + 20, 0, 0, 0, 1));
        step("h_ps", 0, 0, 1, 1, 32'h0040_0900, mk(RPC + 20, 0, 0, 0, 1));
        idle("h_idle", mk(RPC + 20, 0, 0, 0, 1));
        do_reset("rst_h");
        idle("boot2", mk(RPC, 0, 0, 0, 0));
        step("park", 1, 0, 1, 0, 32'h0040_0500, mk(RPC, 0, 0, 0, 0));
        do_reset("rst_p");
        idle("boot3", mk(RPC, 0, 0, 0, 0));
        idle("nopend", mk(RPC + 4, 32'h2408_0005, RPC + 4, 1, 0));
        step("to_top", 0, 1, 1, 0, 32'hFFFF_FFFF, mk(32'hFFFF_FFFC, 0, 0, 0, 0));
        idle("wrap", mk(32'd0, mem(32'hFFFF_FFFC), 32'd0, 1, 0));
        idle("wrap1", mk(32'd4, mem(32'd0), 32'd4, 1, 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
